tex_req_arb: RTL and testbench
==============================

# tex_req_arb

Round-robin arbiter that shares one texture unit among NUM_REQS requesters (e.g. cores or sockets in a cluster). It selects one pending texture request per cycle, appends the requester index to the request tag, and registers the request toward the texture unit. It also caps in-flight requests at MAX_PENDING and steers each texture response back to its originating requester by the appended index.

## Interface
- NUM_REQS, 4, number of requesters; legal range 2..8. LOG_REQS = clog2(NUM_REQS).
- NUM_LANES, 4, lanes per request.
- TAG_WIDTH, 16, requester-side tag width; texture-side tag is TAG_WIDTH+LOG_REQS.
- LOD_BITS, 4, per-lane LOD width. STAGE_BITS, 1, stage select width.
- MAX_PENDING, 16, maximum outstanding requests at the texture unit; must be ≥1.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQS  per-requester request valid
- req_mask  in  NUM_REQS×NUM_LANES  lane mask
- req_coords  in  NUM_REQS×2×NUM_LANES×32  u/v coordinates
- req_lod  in  NUM_REQS×NUM_LANES×LOD_BITS  per-lane LOD
- req_stage  in  NUM_REQS×STAGE_BITS  stage select
- req_tag  in  NUM_REQS×TAG_WIDTH  requester tag
- req_ready  out  NUM_REQS  per-requester accept
- rsp_valid  out  NUM_REQS  per-requester response valid
- rsp_texels  out  NUM_LANES×32  shared response texels, broadcast to all requesters
- rsp_tag  out  TAG_WIDTH  shared response tag, broadcast to all requesters
- rsp_ready  in  NUM_REQS  per-requester response ready
- tex_req_valid / mask / coords / lod / stage  out  as above for one requester  registered request to the texture unit
- tex_req_tag  out  TAG_WIDTH+LOG_REQS  {requester index, req_tag}; index occupies the MSBs
- tex_req_ready  in  1  texture unit accept
- tex_rsp_valid  in  1; tex_rsp_texels  in  NUM_LANES×32; tex_rsp_tag  in  TAG_WIDTH+LOG_REQS
- tex_rsp_ready  out  1
- pending_count  out  clog2(MAX_PENDING+1)  current outstanding count, for perf and debug

## Operation
- Round-robin pointer `rr` (LOG_REQS bits). The winner is the first i with req_valid[i], scanning i = rr, rr+1, … modulo NUM_REQS.
- Output register slot (valid + payload):
  - load_en = !tex_req_valid || tex_req_ready.
  - can_issue = load_en && (pending_count < MAX_PENDING).
  - req_ready[i] = can_issue && (i == winner). All other lanes of req_ready are 0.
  - req_ready[i] does not depend on req_valid[i] for any requester other than through winner selection.
- Input fire (req_valid[w] && req_ready[w]):
  - Slot loads the winner payload, with tag {w, req_tag[w]}.
  - rr <= w+1 mod NUM_REQS.
- With no input fire and tex_req_ready=1, the slot clears valid.
- rr does not change when no request fires.
- pending_count:
  - +1 on input fire, −1 on tex_rsp fire, unchanged when both occur in the same cycle.
  - Never wraps.
- Response path is combinational:
  - s = tex_rsp_tag[MSBs].
  - rsp_valid[i] = tex_rsp_valid && (i == s).
  - rsp_texels and rsp_tag (the low TAG_WIDTH bits of tex_rsp_tag) are driven to all requesters.
  - tex_rsp_ready = rsp_ready[s].
- A response with s ≥ NUM_REQS is a protocol error: tex_rsp_ready = 1 (drop), all rsp_valid = 0, assertion fires in simulation.
- A tex_rsp fire while pending_count == 0 is a protocol error: assertion fires; the counter stays at 0.

## Timing
- Reset values: tex_req_valid=0, rr=0, pending_count=0, all req_ready=0 in the reset cycle, rsp_valid follows tex_rsp_valid (combinational).
- Request latency: accepted at edge N, so tex_req_valid=1 from cycle N+1.
- Throughput: one request per cycle while tex_req_ready=1 and the pending cap is not reached.
- Payload and tex_req_valid are held stable while tex_req_valid && !tex_req_ready.
- Response latency: 0 cycles, no buffering.
- Cap boundary: at pending_count == MAX_PENDING, every req_ready is 0.
  - A tex_rsp fire in that cycle does not reopen issue until the next cycle. The counter is compared registered, never bypassed.
- Reset mid-operation: the slot is dropped and counters are cleared. In-flight texture responses after reset are the system's responsibility; the block does not track them.

## Test plan
- Single requester: NUM_REQS=4, only req 2 valid, tag 0x1234, tex_req_ready=1 -> tex_req_valid the next cycle, tex_req_tag={2'd2,0x1234}, pending_count=1; response tag {2,0x1234} -> rsp_valid=4'b0100, rsp_tag=0x1234, pending_count=0.
- Fairness: all 4 valid continuously, tex_req_ready=1, MAX_PENDING large -> grant order 0,1,2,3,0,1…, each requester receives exactly 25 grants in 100 cycles.
- Backpressure: tex_req_ready=0 for 5 cycles with the slot full -> all req_ready=0, tex_req_* payload bit-stable; after ready rises, exactly one fire per cycle.
- Pending cap: MAX_PENDING=2, no responses -> exactly 2 issues, then req_ready=0 indefinitely; one response -> next issue in the following cycle; a simultaneous issue and response holds pending_count at 2.
- Response backpressure: response to req 1 with rsp_ready[1]=0 for 3 cycles -> tex_rsp_ready=0, rsp_valid[1]=1 held, pending_count unchanged until the fire.
- Reset mid-stream: assert reset with the slot full and pending_count=5 -> the next cycle tex_req_valid=0, pending_count=0, rr=0, and the first grant goes to requester 0.

Source files
------------

// File: rtl/tex_req_arb.sv
// rtl/tex_req_arb.sv - round-robin texture request arbiter with pending cap and response steering
module tex_req_arb #(
    parameter int NUM_REQS    = 4,
    parameter int NUM_LANES   = 4,
    parameter int TAG_WIDTH   = 16,
    parameter int LOD_BITS    = 4,
    parameter int STAGE_BITS  = 1,
    parameter int MAX_PENDING = 16,
    localparam int LOG_REQS   = $clog2(NUM_REQS),
    localparam int PCNT_W     = $clog2(MAX_PENDING + 1),
    localparam int CRD_W      = 2 * NUM_LANES * 32,
    localparam int LOD_W      = NUM_LANES * LOD_BITS
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQS-1:0]             req_valid,
    input  logic [NUM_REQS*NUM_LANES-1:0]   req_mask,
    input  logic [NUM_REQS*CRD_W-1:0]       req_coords,
    input  logic [NUM_REQS*LOD_W-1:0]       req_lod,
    input  logic [NUM_REQS*STAGE_BITS-1:0]  req_stage,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]   req_tag,
    output logic [NUM_REQS-1:0]             req_ready,
    output logic [NUM_REQS-1:0]             rsp_valid,
    output logic [NUM_LANES*32-1:0]         rsp_texels,
    output logic [TAG_WIDTH-1:0]            rsp_tag,
    input  logic [NUM_REQS-1:0]             rsp_ready,
    output logic                            tex_req_valid,
    output logic [NUM_LANES-1:0]            tex_req_mask,
    output logic [CRD_W-1:0]                tex_req_coords,
    output logic [LOD_W-1:0]                tex_req_lod,
    output logic [STAGE_BITS-1:0]           tex_req_stage,
    output logic [TAG_WIDTH+LOG_REQS-1:0]   tex_req_tag,
    input  logic                            tex_req_ready,
    input  logic                            tex_rsp_valid,
    input  logic [NUM_LANES*32-1:0]         tex_rsp_texels,
    input  logic [TAG_WIDTH+LOG_REQS-1:0]   tex_rsp_tag,
    output logic                            tex_rsp_ready,
    output logic [PCNT_W-1:0]               pending_count
);

    logic [LOG_REQS-1:0] rr;
    logic [LOG_REQS-1:0] winner;
    logic [LOG_REQS-1:0] rr_next;
    logic [LOG_REQS:0]   scan_sum;
    logic [LOG_REQS-1:0] scan_idx;
    logic                any_valid;
    logic                load_en;
    logic                can_issue;
    logic                fire;
    logic [LOG_REQS-1:0] rsp_idx;
    logic                rsp_bad;
    logic                rsp_fire;
    logic                dec_ok;

    // Scan downward so the last match written is the closest one at or after rr.
    always_comb begin
        winner    = rr;
        any_valid = 1'b0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            scan_sum = {1'b0, rr} + (LOG_REQS + 1)'(k);
            if (scan_sum >= (LOG_REQS + 1)'(NUM_REQS)) begin
                scan_sum = scan_sum - (LOG_REQS + 1)'(NUM_REQS);
            end
            scan_idx = scan_sum[LOG_REQS-1:0];
            if (req_valid[scan_idx]) begin
                winner    = scan_idx;
                any_valid = 1'b1;
            end
        end
    end

    assign rr_next   = (winner == LOG_REQS'(NUM_REQS - 1)) ? '0 : winner + 1'b1;
    assign load_en   = !tex_req_valid || tex_req_ready;
    // The cap uses the registered count only, so a response never reopens issue in its own cycle.
    assign can_issue = !reset && load_en && (pending_count < PCNT_W'(MAX_PENDING));
    assign fire      = can_issue && any_valid;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            req_ready[i] = can_issue && (winner == LOG_REQS'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tex_req_valid <= 1'b0;
            rr            <= '0;
        end else if (fire) begin
            tex_req_valid <= 1'b1;
            rr            <= rr_next;
        end else if (tex_req_ready) begin
            tex_req_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            tex_req_mask   <= req_mask[winner*NUM_LANES +: NUM_LANES];
            tex_req_coords <= req_coords[winner*CRD_W +: CRD_W];
            tex_req_lod    <= req_lod[winner*LOD_W +: LOD_W];
            tex_req_stage  <= req_stage[winner*STAGE_BITS +: STAGE_BITS];
            tex_req_tag    <= {winner, req_tag[winner*TAG_WIDTH +: TAG_WIDTH]};
        end
    end

    assign rsp_idx       = tex_rsp_tag[TAG_WIDTH +: LOG_REQS];
    assign rsp_bad       = 32'(rsp_idx) >= NUM_REQS;
    assign tex_rsp_ready = rsp_bad || rsp_ready[rsp_idx];
    assign rsp_fire      = tex_rsp_valid && tex_rsp_ready;
    assign rsp_texels    = tex_rsp_texels;
    assign rsp_tag       = tex_rsp_tag[TAG_WIDTH-1:0];

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            rsp_valid[i] = tex_rsp_valid && !rsp_bad && (rsp_idx == LOG_REQS'(i));
        end
    end

    // A stray response at zero must not wrap the counter.
    assign dec_ok = rsp_fire && (pending_count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_count <= '0;
        end else begin
            case ({fire, dec_ok})
                2'b10:   pending_count <= pending_count + 1'b1;
                2'b01:   pending_count <= pending_count - 1'b1;
                default: pending_count <= pending_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(tex_rsp_valid && rsp_bad));
            assert (!(rsp_fire && pending_count == '0));
        end
    end

endmodule

// File: tb/tb_tex_req_arb.sv
// tb/tb_tex_req_arb.sv - randomized and directed bench for tex_req_arb against a queue-based model
module tb_tex_req_arb;
    localparam int N    = 4;
    localparam int NL   = 4;
    localparam int TW   = 16;
    localparam int LB   = 4;
    localparam int SB   = 1;
    localparam int MAXP = 6;
    localparam int LR   = 2;
    localparam int PCW  = 3;
    localparam int CW   = 2 * NL * 32;
    localparam int LW   = NL * LB;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [N-1:0]       req_valid;
    logic [N*NL-1:0]    req_mask;
    logic [N*CW-1:0]    req_coords;
    logic [N*LW-1:0]    req_lod;
    logic [N*SB-1:0]    req_stage;
    logic [N*TW-1:0]    req_tag;
    logic [N-1:0]       req_ready;
    logic [N-1:0]       rsp_valid;
    logic [NL*32-1:0]   rsp_texels;
    logic [TW-1:0]      rsp_tag;
    logic [N-1:0]       rsp_ready;
    logic               tex_req_valid;
    logic [NL-1:0]      tex_req_mask;
    logic [CW-1:0]      tex_req_coords;
    logic [LW-1:0]      tex_req_lod;
    logic [SB-1:0]      tex_req_stage;
    logic [TW+LR-1:0]   tex_req_tag;
    logic               tex_req_ready;
    logic               tex_rsp_valid;
    logic [NL*32-1:0]   tex_rsp_texels;
    logic [TW+LR-1:0]   tex_rsp_tag;
    logic               tex_rsp_ready;
    logic [PCW-1:0]     pending_count;

    tex_req_arb #(
        .NUM_REQS(N), .NUM_LANES(NL), .TAG_WIDTH(TW), .LOD_BITS(LB),
        .STAGE_BITS(SB), .MAX_PENDING(MAXP)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_mask(req_mask), .req_coords(req_coords),
        .req_lod(req_lod), .req_stage(req_stage), .req_tag(req_tag),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_texels(rsp_texels),
        .rsp_tag(rsp_tag), .rsp_ready(rsp_ready),
        .tex_req_valid(tex_req_valid), .tex_req_mask(tex_req_mask),
        .tex_req_coords(tex_req_coords), .tex_req_lod(tex_req_lod),
        .tex_req_stage(tex_req_stage), .tex_req_tag(tex_req_tag),
        .tex_req_ready(tex_req_ready), .tex_rsp_valid(tex_rsp_valid),
        .tex_rsp_texels(tex_rsp_texels), .tex_rsp_tag(tex_rsp_tag),
        .tex_rsp_ready(tex_rsp_ready), .pending_count(pending_count)
    );

    // Model state: the slot contents, the fairness pointer and the list of outstanding tags.
    logic             m_slot_v;
    logic [NL-1:0]    m_mask;
    logic [CW-1:0]    m_coords;
    logic [LW-1:0]    m_lod;
    logic [SB-1:0]    m_stage;
    logic [TW+LR-1:0] m_tag;
    int               m_rr;
    logic [TW+LR-1:0] outq[$];
    int               grants[$];
    int               exp_w;
    bit               exp_fire;
    bit               exp_rsp_fire;
    int               n_tests = 0;
    int               n_fail  = 0;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rand_payload();
        for (int i = 0; i < N * CW / 32; i++) req_coords[i*32 +: 32] = $urandom();
        for (int i = 0; i < N; i++) begin
            req_tag[i*TW +: TW] = TW'($urandom());
            req_lod[i*LW +: LW] = LW'($urandom());
        end
        req_mask  = (N*NL)'($urandom());
        req_stage = (N*SB)'($urandom());
        for (int i = 0; i < NL; i++) tex_rsp_texels[i*32 +: 32] = $urandom();
    endtask

    task automatic compare();
        bit any;
        bit can;
        int s;
        logic [N-1:0] er;
        logic [N-1:0] ev;
        any = 0;
        exp_w = m_rr;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (!any && req_valid[i]) begin
                exp_w = i;
                any = 1;
            end
        end
        can = !reset && (!m_slot_v || tex_req_ready) && (outq.size() < MAXP);
        er = '0;
        if (can) er[exp_w] = 1'b1;
        exp_fire = any && can;
        chk("req_ready", req_ready, er);
        chk("tex_req_valid", tex_req_valid, m_slot_v);
        if (m_slot_v) begin
            chk("tex_req_mask", tex_req_mask, m_mask);
            chk("tex_req_coords", tex_req_coords, m_coords);
            chk("tex_req_lod", tex_req_lod, m_lod);
            chk("tex_req_stage", tex_req_stage, m_stage);
            chk("tex_req_tag", tex_req_tag, m_tag);
        end
        chk("pending_count", pending_count, CW'(outq.size()));
        s = int'(tex_rsp_tag) >> TW;
        ev = '0;
        if (tex_rsp_valid) ev[s] = 1'b1;
        chk("rsp_valid", rsp_valid, ev);
        if (tex_rsp_valid) begin
            chk("rsp_tag", rsp_tag, tex_rsp_tag % (1 << TW));
            chk("rsp_texels", rsp_texels, tex_rsp_texels);
        end
        chk("tex_rsp_ready", tex_rsp_ready, rsp_ready[s]);
        exp_rsp_fire = tex_rsp_valid && rsp_ready[s];
    endtask

    task automatic model_update();
        if (reset) begin
            m_slot_v = 0;
            m_rr = 0;
            outq.delete();
        end else begin
            if (exp_rsp_fire) begin
                for (int j = 0; j < outq.size(); j++) begin
                    if (outq[j] == tex_rsp_tag) begin
                        outq.delete(j);
                        break;
                    end
                end
            end
            if (exp_fire) begin
                m_slot_v = 1;
                m_mask   = req_mask[exp_w*NL +: NL];
                m_coords = req_coords[exp_w*CW +: CW];
                m_lod    = req_lod[exp_w*LW +: LW];
                m_stage  = req_stage[exp_w*SB +: SB];
                m_tag    = {LR'(exp_w), req_tag[exp_w*TW +: TW]};
                outq.push_back(m_tag);
                grants.push_back(exp_w);
                m_rr = (exp_w + 1) % N;
            end else if (tex_req_ready) begin
                m_slot_v = 0;
            end
        end
    endtask

    // Inputs are set at the falling edge; check #1 later, update the model at the rising edge.
    task automatic cycle();
        #1;
        compare();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    int g0;
    int cnt[N];
    int bad;
    int idx1;

    initial begin
        reset = 1; req_valid = '0; req_mask = '0; req_coords = '0; req_lod = '0;
        req_stage = '0; req_tag = '0; rsp_ready = '0; tex_req_ready = 0;
        tex_rsp_valid = 0; tex_rsp_texels = '0; tex_rsp_tag = '0;
        m_slot_v = 0; m_rr = 0; m_mask = '0; m_coords = '0; m_lod = '0; m_stage = '0; m_tag = '0;
        @(negedge clk);
        req_valid = '1;
        cycle();
        cycle();
        chk("reset_tex_req_valid", tex_req_valid, 0);
        chk("reset_pending", pending_count, 0);
        reset = 0;

        // Single requester
        req_valid = 4'b0100;
        req_tag[2*TW +: TW] = 16'h1234;
        tex_req_ready = 1;
        cycle();
        req_valid = '0;
        chk("single_tag", tex_req_tag, 18'h21234);
        chk("single_valid", tex_req_valid, 1);
        chk("single_pending", pending_count, 1);
        tex_rsp_valid = 1; tex_rsp_tag = 18'h21234; rsp_ready = '1;
        #1;
        chk("single_rsp_valid", rsp_valid, 4'b0100);
        chk("single_rsp_tag", rsp_tag, 16'h1234);
        cycle();
        tex_rsp_valid = 0;
        chk("single_pending_after", pending_count, 0);

        // Fairness from a fresh reset
        reset = 1; cycle(); reset = 0;
        req_valid = '1; tex_req_ready = 1; rsp_ready = '1;
        g0 = grants.size();
        for (int c = 0; c < 100; c++) begin
            rand_payload();
            tex_rsp_valid = outq.size() > 0;
            if (outq.size() > 0) tex_rsp_tag = outq[0];
            cycle();
        end
        tex_rsp_valid = 0;
        chk("fair_total", CW'(grants.size() - g0), 100);
        bad = 0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int k = g0; k < grants.size(); k++) begin
            cnt[grants[k]]++;
            if (grants[k] != (k - g0) % 4) bad++;
        end
        chk("fair_order_errors", CW'(bad), 0);
        for (int i = 0; i < N; i++) chk($sformatf("fair_count_%0d", i), CW'(cnt[i]), 25);

        // Backpressure with a full slot
        tex_req_ready = 0;
        for (int c = 0; c < 5; c++) begin
            rand_payload();
            #1 chk("bp_req_ready", req_ready, 4'b0000);
            cycle();
        end
        tex_req_ready = 1;
        g0 = grants.size();
        for (int c = 0; c < 4; c++) cycle();
        chk("bp_fires", CW'(grants.size() - g0), 4);
        chk("bp_pending", pending_count, 5);

        // Reset mid-stream with slot full and five outstanding
        chk("mid_slot_full", tex_req_valid, 1);
        reset = 1; cycle(); reset = 0;
        chk("mid_valid", tex_req_valid, 0);
        chk("mid_pending", pending_count, 0);
        #1 chk("mid_first_grant", req_ready, 4'b0001);

        // Pending cap
        reset = 1; cycle(); reset = 0;
        g0 = grants.size();
        for (int c = 0; c < 10; c++) cycle();
        chk("cap_issues", CW'(grants.size() - g0), 6);
        chk("cap_pending", pending_count, 6);
        chk("cap_req_ready", req_ready, 4'b0000);
        tex_rsp_valid = 1; tex_rsp_tag = outq[0];
        #1 chk("cap_same_cycle", req_ready, 4'b0000);
        cycle();
        tex_rsp_tag = outq[0];
        #1 chk("cap_reopen", req_ready, 4'b0100);
        cycle();
        tex_rsp_valid = 0;
        chk("cap_hold", pending_count, 5);

        // Response backpressure on requester 1
        req_valid = '0;
        idx1 = -1;
        for (int j = outq.size() - 1; j >= 0; j--) if (outq[j][TW +: LR] == 2'd1) idx1 = j;
        chk("rbp_found", CW'(idx1 >= 0), 1);
        if (idx1 >= 0) begin
            tex_rsp_valid = 1; tex_rsp_tag = outq[idx1]; rsp_ready = 4'b1101;
            for (int c = 0; c < 3; c++) begin
                #1;
                chk("rbp_rsp_valid", rsp_valid, 4'b0010);
                chk("rbp_tex_rsp_ready", tex_rsp_ready, 0);
                cycle();
            end
            chk("rbp_pending_held", pending_count, 5);
            rsp_ready = '1;
            cycle();
            tex_rsp_valid = 0;
            chk("rbp_pending_after", pending_count, 4);
        end

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rand_payload();
            req_valid = ($urandom_range(0, 3) == 0) ? N'($urandom() & $urandom()) : N'($urandom());
            tex_req_ready = $urandom_range(0, 3) != 0;
            rsp_ready = N'($urandom());
            tex_rsp_valid = (outq.size() > 0) && ($urandom_range(0, 2) == 0);
            if (tex_rsp_valid) tex_rsp_tag = outq[$urandom_range(0, outq.size() - 1)];
            else tex_rsp_tag = (TW+LR)'($urandom());
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
